// File: rtl/wm8731_deserializer.sv
// I2S receive path for the WM8731 ADC: synchronizes BCLK/ADCLRC/ADCDAT into clk,
// recovers left/right WIDTH-bit words and presents them as a pair with a valid strobe.
module wm8731_deserializer #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bclk,
    input  logic             adc_lr_ck,
    input  logic             adc_dat,
    output logic [WIDTH-1:0] audio_l,
    output logic [WIDTH-1:0] audio_r,
    output logic             valid,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_t;

    logic [SYNC_STAGES-1:0] bclk_sync_reg;
    logic [SYNC_STAGES-1:0] lr_sync_reg;
    logic [SYNC_STAGES-1:0] dat_sync_reg;

    logic             bclk_s, lr_s, dat_s;
    logic             rise, lr_edge;
    logic [WIDTH-1:0] word;

    state_t           state_reg, state_next;
    logic             bclk_prev_reg, bclk_prev_next;
    logic             lr_prev_reg, lr_prev_next;
    logic             primed_reg, primed_next;
    logic             channel_reg, channel_next;
    logic             left_ok_reg, left_ok_next;
    logic [WIDTH-1:0] left_hold_reg, left_hold_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] audio_l_reg, audio_l_next;
    logic [WIDTH-1:0] audio_r_reg, audio_r_next;
    logic             valid_reg, valid_next;
    logic             frame_err_reg, frame_err_next;

    // Equal-depth chains keep the three pins mutually aligned after synchronization.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync_reg <= '0;
            lr_sync_reg   <= '0;
            dat_sync_reg  <= '0;
        end else begin
            bclk_sync_reg <= {bclk_sync_reg[SYNC_STAGES-2:0], bclk};
            lr_sync_reg   <= {lr_sync_reg[SYNC_STAGES-2:0], adc_lr_ck};
            dat_sync_reg  <= {dat_sync_reg[SYNC_STAGES-2:0], adc_dat};
        end
    end

    assign bclk_s = bclk_sync_reg[SYNC_STAGES-1];
    assign lr_s   = lr_sync_reg[SYNC_STAGES-1];
    assign dat_s  = dat_sync_reg[SYNC_STAGES-1];

    assign rise = bclk_s & ~bclk_prev_reg;
    // The first rise after reset only learns the LRCK level, so a level that was
    // already high at reset is not mistaken for a fresh channel start.
    assign lr_edge = rise & primed_reg & (lr_s ^ lr_prev_reg);
    assign word    = {shift_reg[WIDTH-2:0], dat_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            bclk_prev_reg <= 1'b0;
            lr_prev_reg   <= 1'b0;
            primed_reg    <= 1'b0;
            channel_reg   <= 1'b0;
            left_ok_reg   <= 1'b0;
            left_hold_reg <= '0;
            shift_reg     <= '0;
            count_reg     <= '0;
            audio_l_reg   <= '0;
            audio_r_reg   <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bclk_prev_reg <= bclk_prev_next;
            lr_prev_reg   <= lr_prev_next;
            primed_reg    <= primed_next;
            channel_reg   <= channel_next;
            left_ok_reg   <= left_ok_next;
            left_hold_reg <= left_hold_next;
            shift_reg     <= shift_next;
            count_reg     <= count_next;
            audio_l_reg   <= audio_l_next;
            audio_r_reg   <= audio_r_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bclk_prev_next = bclk_s;
        lr_prev_next   = lr_prev_reg;
        primed_next    = primed_reg;
        channel_next   = channel_reg;
        left_ok_next   = left_ok_reg;
        left_hold_next = left_hold_reg;
        shift_next     = shift_reg;
        count_next     = count_reg;
        audio_l_next   = audio_l_reg;
        audio_r_next   = audio_r_reg;
        valid_next     = 1'b0;
        frame_err_next = 1'b0;

        if (rise) begin
            primed_next  = 1'b1;
            lr_prev_next = lr_s;
        end

        case (state_reg)
            IDLE: begin
                if (lr_edge) begin
                    state_next   = SKIP;
                    channel_next = lr_s;
                end
            end
            // The rise that revealed the LRCK edge is the I2S delay slot, so the
            // next rise already carries the MSB.
            SKIP: begin
                if (lr_edge) begin
                    frame_err_next = 1'b1;
                    left_ok_next   = 1'b0;
                    channel_next   = lr_s;
                end else begin
                    count_next = '0;
                    shift_next = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (rise) begin
                    shift_next = word;
                    if (count_reg == CW'(WIDTH - 1)) begin
                        count_next = CW'(WIDTH);
                        state_next = HOLD;
                        if (!channel_reg) begin
                            left_hold_next = word;
                            left_ok_next   = 1'b1;
                        end else if (left_ok_reg) begin
                            audio_l_next = left_hold_reg;
                            audio_r_next = word;
                            valid_next   = 1'b1;
                            left_ok_next = 1'b0;
                        end
                        // The final bit wins over a coincident edge; the edge then starts the next word.
                        if (lr_edge) begin
                            state_next   = SKIP;
                            channel_next = lr_s;
                        end
                    end else if (lr_edge) begin
                        frame_err_next = 1'b1;
                        left_ok_next   = 1'b0;
                        channel_next   = lr_s;
                        state_next     = SKIP;
                    end else begin
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (lr_edge) begin
                    state_next   = SKIP;
                    channel_next = lr_s;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign audio_l   = audio_l_reg;
    assign audio_r   = audio_r_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_wm8731_deserializer.sv
// Directed bench for wm8731_deserializer: builds an I2S bit stream, plays it on the pins
// and scoreboards every valid pair (data and exact latency) plus frame_err pulses.
`timescale 1ns/1ps
module tb_wm8731_deserializer;

    localparam int WIDTH = 16;
    localparam int SYNC  = 2;
    localparam int HALF  = 8;
    localparam int DEPTH = 2048;

    logic             clk = 1'b0;
    logic             reset;
    logic             bclk, adc_lr_ck, adc_dat;
    logic [WIDTH-1:0] audio_l, audio_r;
    logic             valid, frame_err;

    wm8731_deserializer #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .bclk(bclk), .adc_lr_ck(adc_lr_ck), .adc_dat(adc_dat),
        .audio_l(audio_l), .audio_r(audio_r), .valid(valid), .frame_err(frame_err)
    );

    always #2 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] l;
        logic [WIDTH-1:0] r;
        int               cyc;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int ferr_cnt = 0;
    int exp_ferr = 0;

    logic             lr_arr   [DEPTH];
    logic             dat_arr  [DEPTH];
    logic             flag_arr [DEPTH];
    logic [WIDTH-1:0] el_arr   [DEPTH];
    logic [WIDTH-1:0] er_arr   [DEPTH];
    int wp = 0;
    int pp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Channel of n rises: rise 0 is the delay slot, word bits follow MSB first,
    // spilling into the next channel's delay slot when n is only WIDTH.
    task automatic add_channel(input logic lr, input logic [WIDTH-1:0] w, input int n);
        for (int k = 0; k < n; k++) lr_arr[wp + k] = lr;
        for (int i = 0; i < WIDTH; i++) dat_arr[wp + 1 + i] = w[WIDTH-1-i];
        wp += n;
    endtask

    task automatic add_frame(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                             input int nl, input int nr, input bit expect_valid);
        int rs;
        add_channel(1'b0, l, nl);
        rs = wp;
        add_channel(1'b1, r, nr);
        if (expect_valid) begin
            flag_arr[rs + WIDTH] = 1'b1;
            el_arr[rs + WIDTH]   = l;
            er_arr[rs + WIDTH]   = r;
        end
    endtask

    task automatic play(input int to);
        for (int i = pp; i < to; i++) begin
            @(posedge clk); #1;
            bclk      = 1'b0;
            adc_lr_ck = lr_arr[i];
            adc_dat   = dat_arr[i];
            repeat (HALF) @(posedge clk);
            #1;
            bclk = 1'b1;
            if (flag_arr[i]) sb_q.push_back('{el_arr[i], er_arr[i], cyc + SYNC + 1});
            repeat (HALF - 1) @(posedge clk);
        end
        pp = to;
    endtask

    task automatic step_check(input string tag);
        check({tag, "_frame_err_count"}, ferr_cnt, exp_ferr);
        check({tag, "_pending_valids"}, sb_q.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_audio_l"}, audio_l, 0);
        check({tag, "_audio_r"}, audio_r, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_frame_err"}, frame_err, 0);
    endtask

    bit   exp_v;
    exp_t head;
    always @(negedge clk) begin
        if (!reset) begin
            exp_v = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
            if (valid || exp_v) begin
                check("valid_timing", valid, exp_v);
                if (exp_v) begin
                    head = sb_q.pop_front();
                    if (valid) begin
                        check("audio_l", audio_l, head.l);
                        check("audio_r", audio_r, head.r);
                    end
                end
                $display("cyc %0d valid=%0b L=0x%04h R=0x%04h", cyc, valid, audio_l, audio_r);
            end
            if (frame_err) begin
                ferr_cnt++;
                check("valid_with_frame_err", valid, 0);
                $display("cyc %0d frame_err pulse #%0d", cyc, ferr_cnt);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            dat_arr[i]  = 1'($urandom);
            lr_arr[i]   = 1'b0;
            flag_arr[i] = 1'b0;
            el_arr[i]   = '0;
            er_arr[i]   = '0;
        end
        reset = 1'b1; bclk = 1'b0; adc_lr_ck = 1'b0; adc_dat = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");

        // bclk toggling with constant ADCLRC
        add_channel(1'b0, 16'h0000, 20);
        play(wp);
        step_check("idle_bclk");

        // partial first frame (right only), then nominal frames
        add_channel(1'b1, 16'h5A5A, 32);
        for (int f = 0; f < 3; f++) add_frame(16'hA5C3, 16'h1234, 32, 32, 1'b1);
        play(wp);
        step_check("nominal");

        add_frame(16'h8000, 16'h7FFF, 32, 32, 1'b1);
        add_frame(16'hFFFF, 16'h0000, 32, 32, 1'b1);
        play(wp);
        step_check("extremes");

        // left cut after 10 bits: error, next right dropped, following frame recovers
        add_channel(1'b0, 16'hC0DE, 11);
        add_channel(1'b1, 16'hBEEF, 32);
        add_frame(16'h0F0F, 16'hF0F0, 32, 32, 1'b1);
        exp_ferr++;
        play(wp);
        step_check("short_word");

        add_frame(16'h3C5A, 16'hA5C3, 24, 24, 1'b1);
        add_frame(16'h0001, 16'h8001, 24, 24, 1'b1);
        play(wp);
        step_check("extra_bits");

        // LSB and the next LRCK edge on the same bclk rise
        add_frame(16'h1357, 16'h2468, 16, 16, 1'b1);
        add_frame(16'h5555, 16'hAAAA, 32, 32, 1'b1);
        play(wp);
        step_check("lsb_with_edge");

        // reset at bit 8 of a right word
        begin
            int rs;
            add_channel(1'b0, 16'h9999, 32);
            rs = wp;
            add_channel(1'b1, 16'h6666, 32);
            play(rs + 9);
            #1 reset = 1'b1;
            repeat (5) @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            check_zero_outputs("mid_reset");
            play(wp);
        end
        add_frame(16'hCAFE, 16'hF00D, 32, 32, 1'b1);
        play(wp);
        repeat (20) @(posedge clk);
        step_check("reset_recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wm8731_deserializer.md
# wm8731_deserializer

Receive path for the WM8731 codec: recovers 16-bit stereo ADC samples from the codec's I2S output (ADCDAT, ADCLRC, BCLK) and presents them as parallel words with a one-cycle valid strobe in the 240 MHz domain. It is the counterpart of the DAC serializer in the WM8731 controller. It shares that controller's clock, reset and BCLK, and feeds the downstream audio DSP.

## Interface
- WIDTH, 16, sample width in bits per channel
- SYNC_STAGES, 2, synchronizer flops on each pin input (≥2)
- clk  in  1  240 MHz system clock
- reset  in  1  synchronous, active-high reset
- bclk  in  1  bit clock, same net the serializer drives to the codec, nominally 2 MHz
- adc_lr_ck  in  1  ADCLRC. Low selects the left channel, high the right.
- adc_dat  in  1  ADCDAT, serial data from the codec
- audio_l  out  WIDTH  last complete left sample, two's complement
- audio_r  out  WIDTH  last complete right sample, two's complement
- valid  out  1  one-clk pulse when audio_l and audio_r update together
- frame_err  out  1  one-clk pulse when a channel word is cut short

## Operation
- All three pins pass through SYNC_STAGES flops with identical depth, so bclk, adc_lr_ck and adc_dat stay mutually aligned.
- The synchronized adc_dat is sampled only on synchronized bclk rising edges. A rising edge is sync output = 1 with its previous value = 0.
- An LRCK edge is any change of the synchronized adc_lr_ck, detected at a bclk rising edge. Channel = new level.
- Format is I2S: MSB on the 2nd bclk rise after the LRCK edge, MSB first, WIDTH bits. Any bits after the LSB are ignored.
- FSM states: IDLE, SKIP, SHIFT, HOLD.
  - IDLE: after reset, wait for the first LRCK edge, then go to SKIP.
  - SKIP: consume exactly one bclk rise (the I2S delay slot), clear the bit counter, go to SHIFT.
  - SHIFT: shift adc_dat into the shift register on each bclk rise and increment the counter. When the WIDTH-th bit is shifted in, complete the word and go to HOLD.
  - HOLD: ignore data until the next LRCK edge, then go to SKIP.
  - An LRCK edge in SKIP or in SHIFT with fewer than WIDTH bits:
    - pulse frame_err;
    - discard the partial word;
    - clear left_ok;
    - go to SKIP with the new channel.
- Word completion:
  - Left word: copy to an internal left_hold register and set left_ok.
  - Right word with left_ok = 1: audio_l <= left_hold, audio_r <= completed word, valid pulses, left_ok cleared.
  - Right word with left_ok = 0 (first frame after reset, or after an error): dropped silently. No valid, no error.
- audio_l and audio_r change only when valid pulses and otherwise hold their value indefinitely.
- Bit counter width is clog2(WIDTH+1). It saturates at WIDTH in HOLD and never wraps.

## Timing
- Reset values: audio_l = 0, audio_r = 0, valid = 0, frame_err = 0, state = IDLE, left_ok = 0, counter = 0, shift register = 0, all sync flops = 0.
- Reset is sampled on clk. Asserting it mid-word aborts the word with no valid and no frame_err. Capture resumes only after a fresh LRCK edge.
- Latency: with SYNC_STAGES = 2, valid is high during the 3rd clk cycle after the clk edge that first samples the right-channel LSB bclk rise at the pin.
  - audio_l and audio_r are valid in that same cycle.
  - Latency is SYNC_STAGES+1 in general.
- valid and frame_err are each exactly one clk wide and never high in the same cycle.
- Requirements on the incoming signals:
  - bclk high and low phases each ≥ SYNC_STAGES+1 clk periods (2 MHz gives 60).
  - adc_dat changes on the bclk falling edge; the synchronized rise samples it mid-bit.
  - adc_lr_ck changes on the bclk falling edge.
- Simultaneous LRCK edge and WIDTH-th bit on the same bclk rise: the bit completes the word first, then the edge is taken. No frame_err.

## Test plan
- Reset: hold reset 10 clk, release. All outputs must be 0. Toggle bclk with adc_lr_ck constant: valid and frame_err must stay 0.
- Nominal frame: drive 2 MHz bclk and 32 kHz adc_lr_ck in I2S format with L = 0xA5C3, R = 0x1234.
  - The first partial frame after reset produces no valid.
  - Each subsequent frame produces exactly one valid with audio_l = 0xA5C3 and audio_r = 0x1234, 3 clk after the pin-level R LSB rise.
- Extremes: L = 0x8000, R = 0x7FFF, followed by L = 0xFFFF, R = 0x0000. Outputs must match exactly. No sign extension or bit slip.
- Short word: toggle adc_lr_ck after 10 left bits. frame_err pulses once. The next right word gives no valid. The following full frame gives a valid with correct data.
- Extra bits: send 24 bclk rises per channel with the valid word in the first 16 bits after the delay slot. Outputs equal the 16-bit words and trailing bits are ignored.
- Reset mid-word: assert reset at bit 8 of a right word. No valid and no frame_err at any point. Capture recovers on the next full L/R frame.
